uart_tx_arbiter: RTL and testbench

//  Shares the single UART transmit char port (uart_io_char/uart_io_we/uart_io_full) between two

---
 rtl/uart_arb_pkg.sv | 16 +
 rtl/uart_arb_fifo.sv | 45 ++++
 rtl/uart_tx_arbiter.sv | 127 ++++++++++++
 tb/tb_uart_tx_arbiter.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_arb_pkg.sv
// rtl/uart_arb_pkg.sv - FSM states, grant encodings and defaults for the UART TX arbiter
package uart_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_GRANT0 = 2'd1,
        ST_GRANT1 = 2'd2
    } arb_state_t;

    localparam logic [7:0] EOL_CHAR_DEFAULT = 8'h0A;

    localparam logic [1:0] GRANT_NONE = 2'b00;
    localparam logic [1:0] GRANT_REQ0 = 2'b01;
    localparam logic [1:0] GRANT_REQ1 = 2'b10;

endpackage

// File: rtl/uart_arb_fifo.sv
// rtl/uart_arb_fifo.sv - per-requester sync FIFO, wrap-around pointers with an extra lap bit
module uart_arb_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    // Same index with differing lap bits means the writer is a full lap ahead.
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty    = (wr_ptr == rd_ptr);
    assign pop_data = mem[rd_ptr[AW-1:0]];
    assign do_push  = push & ~full;
    assign do_pop   = pop & ~empty;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin share of the UART TX char port; UART_ARB_LINE_LOCK_EN holds grant per line
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int         FIFO_DEPTH   = 4,
    parameter int         LOCK_TIMEOUT = 1024,
    parameter logic [7:0] EOL_CHAR     = EOL_CHAR_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] req0_char,
    input  logic       req0_we,
    output logic       req0_full,
    output logic       req0_drop,
    input  logic [7:0] req1_char,
    input  logic       req1_we,
    output logic       req1_full,
    output logic       req1_drop,
    output logic [7:0] uart_io_char,
    output logic       uart_io_we,
    input  logic       uart_io_full,
    output logic [1:0] arb_grant
);

    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || LOCK_TIMEOUT < 1 ||
        $bits(EOL_CHAR) != 8) begin : g_bad_params
        $error("uart_tx_arbiter: invalid parameters");
    end

    arb_state_t state;
    logic       rr_ptr;
    logic       empty0, empty1;
    logic [7:0] data0, data1;
    logic       pop0, pop1;
    logic       in_grant, cur_sel, cur_empty, issue;
    logic [7:0] cur_data;
    logic       release_on_issue, release_on_empty;

    uart_arb_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_fifo0 (
        .clk(clk), .rst(rst), .push(req0_we), .push_data(req0_char),
        .pop(pop0), .pop_data(data0), .full(req0_full), .empty(empty0)
    );

    uart_arb_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_fifo1 (
        .clk(clk), .rst(rst), .push(req1_we), .push_data(req1_char),
        .pop(pop1), .pop_data(data1), .full(req1_full), .empty(empty1)
    );

    assign in_grant  = (state != ST_IDLE);
    assign cur_sel   = (state == ST_GRANT1);
    assign cur_empty = cur_sel ? empty1 : empty0;
    assign cur_data  = cur_sel ? data1 : data0;
    // The ~uart_io_we term inserts a bubble so a late uart_io_full is always seen.
    assign issue     = in_grant & ~cur_empty & ~uart_io_full & ~uart_io_we;
    assign pop0      = issue & ~cur_sel;
    assign pop1      = issue & cur_sel;

`ifdef UART_ARB_LINE_LOCK_EN
    localparam int             TMO_W    = $clog2(LOCK_TIMEOUT + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(LOCK_TIMEOUT - 1);

    logic [TMO_W-1:0] tmo_cnt;
    logic             cur_push;

    assign cur_push         = cur_sel ? (req1_we & ~req1_full) : (req0_we & ~req0_full);
    assign release_on_issue = (cur_data == EOL_CHAR);
    assign release_on_empty = ~cur_push && (tmo_cnt == TMO_LAST);

    // Counts consecutive empty cycles of the locked FIFO; any push restarts the wait.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tmo_cnt <= '0;
        end else if (!in_grant || cur_push || !cur_empty || tmo_cnt == TMO_LAST) begin
            tmo_cnt <= '0;
        end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
        end
    end
`else
    assign release_on_issue = 1'b1;
    assign release_on_empty = 1'b1;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= ST_IDLE;
            rr_ptr       <= 1'b0;
            uart_io_char <= 8'h00;
            uart_io_we   <= 1'b0;
            arb_grant    <= GRANT_NONE;
            req0_drop    <= 1'b0;
            req1_drop    <= 1'b0;
        end else begin
            req0_drop  <= req0_we & req0_full;
            req1_drop  <= req1_we & req1_full;
            uart_io_we <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (!empty0 && (empty1 || !rr_ptr)) begin
                        state     <= ST_GRANT0;
                        arb_grant <= GRANT_REQ0;
                    end else if (!empty1) begin
                        state     <= ST_GRANT1;
                        arb_grant <= GRANT_REQ1;
                    end
                end
                ST_GRANT0, ST_GRANT1: begin
                    if (issue) begin
                        uart_io_char <= cur_data;
                        uart_io_we   <= 1'b1;
                    end
                    // On release the other requester gets first claim next time.
                    if ((issue && release_on_issue) || (cur_empty && release_on_empty)) begin
                        state     <= ST_IDLE;
                        arb_grant <= GRANT_NONE;
                        rr_ptr    <= ~cur_sel;
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    arb_grant <= GRANT_NONE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - directed vector bench for uart_tx_arbiter
module tb_uart_tx_arbiter;

    localparam int TMO = 16;
`ifdef UART_ARB_LINE_LOCK_EN
    localparam bit LOCK = 1'b1;
`else
    localparam bit LOCK = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] req0_char = 8'h00;
    logic       req0_we = 1'b0;
    logic       req0_full, req0_drop;
    logic [7:0] req1_char = 8'h00;
    logic       req1_we = 1'b0;
    logic       req1_full, req1_drop;
    logic [7:0] uart_io_char;
    logic       uart_io_we;
    logic       uart_io_full = 1'b0;
    logic [1:0] arb_grant;

    always #5 clk = ~clk;

    uart_tx_arbiter #(.FIFO_DEPTH(4), .LOCK_TIMEOUT(TMO), .EOL_CHAR(8'h0A)) dut (
        .clk(clk), .rst(rst),
        .req0_char(req0_char), .req0_we(req0_we), .req0_full(req0_full), .req0_drop(req0_drop),
        .req1_char(req1_char), .req1_we(req1_we), .req1_full(req1_full), .req1_drop(req1_drop),
        .uart_io_char(uart_io_char), .uart_io_we(uart_io_we), .uart_io_full(uart_io_full),
        .arb_grant(arb_grant)
    );

    int         n_cmp = 0;
    int         n_bad = 0;
    logic [7:0] mon_q[$];
    int         b2b_cnt = 0;
    logic       prev_we = 1'b0;

    always @(negedge clk) begin
        if (rst) begin
            prev_we <= 1'b0;
        end else begin
            if (uart_io_we) mon_q.push_back(uart_io_char);
            if (uart_io_we && prev_we) b2b_cnt <= b2b_cnt + 1;
            prev_we <= uart_io_we;
        end
    end

    typedef struct {
        bit         rst;
        bit         we0;
        logic [7:0] c0;
        bit         we1;
        logic [7:0] c1;
        bit         x_we;
        logic [7:0] x_char;
        logic [1:0] x_grant;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input bit r, input bit w0, input logic [7:0] c0, input bit w1,
                       input logic [7:0] c1, input bit xw, input logic [7:0] xc,
                       input logic [1:0] xg);
        vec_t v;
        v.rst = r; v.we0 = w0; v.c0 = c0; v.we1 = w1; v.c1 = c1;
        v.x_we = xw; v.x_char = xc; v.x_grant = xg;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cyc(input bit w0, input logic [7:0] c0, input bit w1, input logic [7:0] c1);
        req0_we = w0; req0_char = c0; req1_we = w1; req1_char = c1;
        tick();
        req0_we = 1'b0; req1_we = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1; req0_we = 1'b0; req1_we = 1'b0; uart_io_full = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        mon_q.delete();
    endtask

    task automatic expect_seq(input string name, input string exp, input int bound);
        int k = 0;
        while (mon_q.size() < exp.len() && k < bound) begin
            tick();
            k++;
        end
        repeat (4) tick();
        check({name, " count"}, mon_q.size(), exp.len());
        for (int i = 0; i < exp.len(); i++) begin
            if (i < mon_q.size()) check($sformatf("%s char%0d", name, i), mon_q[i], exp[i]);
        end
        check({name, " b2b"}, b2b_cnt, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int drops, wes, k;
        logic [1:0] g_lock;
        g_lock = LOCK ? 2'b01 : 2'b00;

        #1 rst = 1'b1;
        #1;
        check("rst we", uart_io_we, 0);
        check("rst char", uart_io_char, 8'h00);
        check("rst grant", arb_grant, 2'b00);
        check("rst full0", req0_full, 0);
        check("rst full1", req1_full, 0);
        check("rst drop0", req0_drop, 0);
        check("rst drop1", req1_drop, 0);

        // Single 'A' on req0: strobe three cycles after the push.
        add(1, 0, 8'h00, 0, 8'h00, 0, 8'h00, 2'b00);
        add(0, 1, 8'h41, 0, 8'h00, 0, 8'h00, 2'b00);
        add(0, 0, 8'h00, 0, 8'h00, 0, 8'h00, 2'b00);
        add(0, 0, 8'h00, 0, 8'h00, 0, 8'h00, 2'b01);
        add(0, 0, 8'h00, 0, 8'h00, 1, 8'h41, g_lock);
        add(0, 0, 8'h00, 0, 8'h00, 0, 8'h41, g_lock);
        add(1, 0, 8'h00, 0, 8'h00, 0, 8'h00, 2'b00);
`ifndef UART_ARB_LINE_LOCK_EN
        // "ab" / "XY" interleaved per char with a bubble between strobes.
        add(0, 1, 8'h61, 1, 8'h58, 0, 8'h00, 2'b00);
        add(0, 1, 8'h62, 1, 8'h59, 0, 8'h00, 2'b00);
        add(0, 0, 8'h00, 0, 8'h00, 0, 8'h00, 2'b01);
        add(0, 0, 8'h00, 0, 8'h00, 1, 8'h61, 2'b00);
        add(0, 0, 8'h00, 0, 8'h00, 0, 8'h61, 2'b10);
        add(0, 0, 8'h00, 0, 8'h00, 1, 8'h58, 2'b00);
        add(0, 0, 8'h00, 0, 8'h00, 0, 8'h58, 2'b01);
        add(0, 0, 8'h00, 0, 8'h00, 1, 8'h62, 2'b00);
        add(0, 0, 8'h00, 0, 8'h00, 0, 8'h62, 2'b10);
        add(0, 0, 8'h00, 0, 8'h00, 1, 8'h59, 2'b00);
        add(0, 0, 8'h00, 0, 8'h00, 0, 8'h59, 2'b00);
`endif

        tick();
        foreach (vecs[i]) begin
            rst = vecs[i].rst;
            req0_we = vecs[i].we0; req0_char = vecs[i].c0;
            req1_we = vecs[i].we1; req1_char = vecs[i].c1;
            @(negedge clk);
            check($sformatf("vec%0d we", i), uart_io_we, vecs[i].x_we);
            check($sformatf("vec%0d char", i), uart_io_char, vecs[i].x_char);
            check($sformatf("vec%0d grant", i), arb_grant, vecs[i].x_grant);
            check($sformatf("vec%0d flags", i), {req0_full, req1_full, req0_drop, req1_drop}, 4'b0000);
            tick();
        end
        rst = 1'b0; req0_we = 1'b0; req1_we = 1'b0;

        do_reset();
        cyc(1, 8'h61, 1, 8'h58);
        cyc(1, 8'h62, 1, 8'h59);
        expect_seq("t2", LOCK ? "abXY" : "aXbY", 100);

        do_reset();
        cyc(1, 8'h68, 0, 8'h00);
        cyc(1, 8'h69, 1, 8'h51);
        cyc(1, 8'h0A, 0, 8'h00);
        expect_seq("t3", LOCK ? "hi\nQ" : "hQi\n", 100);

        do_reset();
        uart_io_full = 1'b1;
        drops = 0;
        wes = 0;
        for (int j = 0; j < 20; j++) begin
            req0_we = (j < 5);
            req0_char = 8'(8'h30 + j);
            @(negedge clk);
            drops += int'(req0_drop);
            wes += int'(uart_io_we);
            if (j == 4) check("t4 full at 4th push", req0_full, 1);
            tick();
        end
        req0_we = 1'b0;
        check("t4 drop pulses", drops, 1);
        check("t4 we while full", wes, 0);
        check("t4 full held", req0_full, 1);
        check("t4 grant waiting", arb_grant, 2'b01);
        uart_io_full = 1'b0;
        expect_seq("t4", "0123", 60);
        check("t4 full after drain", req0_full, 0);

        do_reset();
        cyc(0, 8'h00, 1, 8'h61);
        cyc(0, 8'h00, 1, 8'h62);
        cyc(1, 8'h5A, 0, 8'h00);
`ifdef UART_ARB_LINE_LOCK_EN
        k = 0;
        while (!(uart_io_we && uart_io_char == 8'h62) && k < 20) begin
            @(negedge clk);
            k++;
        end
        check("t5 b issued", uart_io_char, 8'h62);
        k = 0;
        while (arb_grant != 2'b01 && k < TMO + 10) begin
            @(negedge clk);
            k++;
        end
        check("t5 lock hold cycles", k, TMO + 1);
        tick();
`endif
        expect_seq("t5", LOCK ? "abZ" : "aZb", 100);

        do_reset();
        uart_io_full = 1'b1;
        cyc(1, 8'h31, 0, 8'h00);
        cyc(1, 8'h32, 0, 8'h00);
        cyc(1, 8'h33, 0, 8'h00);
        tick();
        tick();
        check("t6 grant before rst", arb_grant, 2'b01);
        check("t6 nothing issued", mon_q.size(), 0);
        rst = 1'b1;
        #1;
        check("t6 rst we", uart_io_we, 0);
        check("t6 rst char", uart_io_char, 8'h00);
        check("t6 rst grant", arb_grant, 2'b00);
        check("t6 rst flags", {req0_full, req1_full, req0_drop, req1_drop}, 4'b0000);
        uart_io_full = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        repeat (20) tick();
        check("t6 no issue after rst", mon_q.size(), 0);
        check("t6 grant idle", arb_grant, 2'b00);
        check("t6 b2b", b2b_cnt, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
